// File: rtl/pulse_counter_pkg.sv
// Shared types and constants for the multi-channel windowed pulse counter.
package pulse_counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    LATCH = 2'b10
  } state_t;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;

  // Picks the edge event selected by edge_mode; code 2'b11 behaves as rising.
  function automatic logic edge_select(input logic [1:0] mode,
                                       input logic rise,
                                       input logic fall);
    logic sel;
    case (mode)
      EDGE_RISE: sel = rise;
      EDGE_FALL: sel = fall;
      EDGE_BOTH: sel = rise | fall;
      default:   sel = rise;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/pulse_edge_detect.sv
// One channel front end: synchroniser, optional glitch filter, edge detector.
// Optional filter enabled by macro PULSE_GLITCH_FILTER_EN.
module pulse_edge_detect
  import pulse_counter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_in,
  input  logic [1:0] edge_mode,
  output logic       edge_pulse
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILT_LEN < 1) begin : g_param_check
    $error("pulse_edge_detect: SYNC_STAGES must be 2..4 and FILT_LEN at least 1");
  end

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   level_s;
  logic                   filt_s;
  logic                   prev_r;
  logic                   rise_s;
  logic                   fall_s;

  // Shift the raw asynchronous input through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pulse_in};
    end
  end

  assign level_s = sync_r[SYNC_STAGES-1];

`ifdef PULSE_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILT_LEN + 1);

  logic [FCW-1:0] stab_r;
  logic           filt_r;

  // Accept a new level only after it has differed for FILT_LEN straight cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_r <= '0;
      filt_r <= 1'b0;
    end else if (level_s != filt_r) begin
      if (stab_r == FCW'(FILT_LEN - 1)) begin
        filt_r <= level_s;
        stab_r <= '0;
      end else begin
        stab_r <= stab_r + FCW'(1'b1);
      end
    end else begin
      stab_r <= '0;
    end
  end

  assign filt_s = filt_r;
`else
  assign filt_s = level_s;
`endif

  // Remember last cycle's filtered level for edge comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= filt_s;
    end
  end

  assign rise_s     = filt_s & ~prev_r;
  assign fall_s     = ~filt_s & prev_r;
  assign edge_pulse = edge_select(edge_mode, rise_s, fall_s);

endmodule

// File: rtl/pulse_counter_mc.sv
// Multi-channel windowed pulse counter: gate-window FSM, timer, saturating
// per-channel accumulators and latched result registers.
// Optional glitch filter in the front end: macro PULSE_GLITCH_FILTER_EN.
module pulse_counter_mc
  import pulse_counter_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 24,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       pulse_in,
  input  logic                    enable,
  input  logic [WIN_W-1:0]        win_len,
  input  logic [1:0]              edge_mode,
  output logic [NUM_CH*CNT_W-1:0] count_out,
  output logic [NUM_CH-1:0]       sat_out,
  output logic                    valid,
  output logic                    busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  state_t                        state_r;
  state_t                        state_s;
  logic                          start_s;
  logic [WIN_W-1:0]              timer_r;
  logic [NUM_CH-1:0]             edge_s;
  logic [NUM_CH-1:0][CNT_W-1:0]  acc_r;
  logic [NUM_CH-1:0]             acc_sat_r;
  logic [NUM_CH*CNT_W-1:0]       count_out_r;
  logic [NUM_CH-1:0]             sat_out_r;
  logic                          valid_r;
  logic                          busy_r;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    pulse_edge_detect #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN   (FILT_LEN)
    ) u_edge (
      .clk       (clk),
      .rst       (rst),
      .pulse_in  (pulse_in[ch]),
      .edge_mode (edge_mode),
      .edge_pulse(edge_s[ch])
    );
  end

  assign start_s = enable && (win_len != '0);

  // Next-state logic: windows chain back to back while enable holds.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_s = COUNT;
        else         state_s = IDLE;
      end
      COUNT: begin
        if (!enable)                        state_s = IDLE;
        else if (timer_r == WIN_W'(1'b1))   state_s = LATCH;
        else                                state_s = COUNT;
      end
      LATCH: begin
        if (start_s) state_s = COUNT;
        else         state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Window timer: loaded from win_len only when a window starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r <= '0;
    end else if (state_r != COUNT && state_s == COUNT) begin
      timer_r <= win_len;
    end else if (state_r == COUNT) begin
      timer_r <= timer_r - WIN_W'(1'b1);
    end else begin
      timer_r <= timer_r;
    end
  end

  // Saturating accumulators; a LATCH-cycle edge seeds the next window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r     <= '0;
      acc_sat_r <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        case (state_r)
          COUNT: begin
            if (!enable) begin
              acc_r[i]     <= '0;
              acc_sat_r[i] <= 1'b0;
            end else if (edge_s[i]) begin
              if (acc_r[i] != CNT_MAX) acc_r[i] <= acc_r[i] + CNT_ONE;
              else                     acc_r[i] <= acc_r[i];
              if (acc_r[i] >= CNT_MAX - CNT_ONE) acc_sat_r[i] <= 1'b1;
              else                               acc_sat_r[i] <= acc_sat_r[i];
            end else begin
              acc_r[i]     <= acc_r[i];
              acc_sat_r[i] <= acc_sat_r[i];
            end
          end
          LATCH: begin
            acc_r[i]     <= edge_s[i] ? CNT_ONE : '0;
            acc_sat_r[i] <= edge_s[i] && (CNT_MAX == CNT_ONE);
          end
          default: begin
            acc_r[i]     <= '0;
            acc_sat_r[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  // Result registers, valid strobe and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_out_r <= '0;
      sat_out_r   <= '0;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      valid_r <= (state_r == LATCH);
      busy_r  <= (state_s != IDLE);
      if (state_r == LATCH) begin
        count_out_r <= acc_r;
        sat_out_r   <= acc_sat_r;
      end else begin
        count_out_r <= count_out_r;
        sat_out_r   <= sat_out_r;
      end
    end
  end

  assign count_out = count_out_r;
  assign sat_out   = sat_out_r;
  assign valid     = valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_pulse_counter_mc.sv
// Self-checking bench for pulse_counter_mc: random pulse trains scored against
// a window-arithmetic reference model, plus directed reset/abort/glitch steps.
module tb_pulse_counter_mc;

  localparam int NCH  = 4;
  localparam int CW   = 4;
  localparam int WW   = 12;
  localparam int SYNC = 2;
  localparam int FL   = 4;
  localparam int MAXC = (1 << CW) - 1;
`ifdef PULSE_GLITCH_FILTER_EN
  localparam int LAT        = SYNC + FL;
  localparam int HMIN       = FL;
  localparam int GLITCH_EXP = 1;
`else
  localparam int LAT        = SYNC;
  localparam int HMIN       = 1;
  localparam int GLITCH_EXP = 2;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    pulse_in;
  logic              enable;
  logic [WW-1:0]     win_len;
  logic [1:0]        edge_mode;
  logic [NCH*CW-1:0] count_out;
  logic [NCH-1:0]    sat_out;
  logic              valid;
  logic              busy;

  always #5 clk = ~clk;

  pulse_counter_mc #(
    .NUM_CH(NCH), .CNT_W(CW), .WIN_W(WW), .SYNC_STAGES(SYNC), .FILT_LEN(FL)
  ) dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .enable(enable),
    .win_len(win_len), .edge_mode(edge_mode), .count_out(count_out),
    .sat_out(sat_out), .valid(valid), .busy(busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int held_cnt [NCH];
  bit held_sat [NCH];
  int exp_cnt  [64][NCH];
  bit lvl      [NCH];
  int hold     [NCH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_held();
    for (int ch = 0; ch < NCH; ch++) begin
      chk($sformatf("count_ch%0d", ch), 64'(count_out[ch*CW +: CW]), 64'(held_cnt[ch]));
      chk($sformatf("sat_ch%0d", ch), 64'(sat_out[ch]), 64'(held_sat[ch]));
    end
  endtask

  // Model: an input toggle at cycle t reaches the counter at t+LAT; window k
  // counts cycles s+k(w+1) .. s+k(w+1)+w-1 and its LATCH cycle feeds window k+1.
  task automatic record(input int ch, input int w, input int s, input int mode);
    int  d;
    int  k;
    bit  hit;
    d   = cyc + LAT;
    hit = (mode == 2) ? 1'b1 : (mode == 1) ? !lvl[ch] : lvl[ch];
    if (w != 0 && d >= s && hit) begin
      k = (d - s + 1) / (w + 1);
      if (k < 64) exp_cnt[k][ch]++;
    end
  endtask

  task automatic toggle(input int ch, input int w, input int s, input int mode);
    lvl[ch]      = !lvl[ch];
    pulse_in[ch] = lvl[ch];
    record(ch, w, s, mode);
  endtask

  task automatic run_phase(input int w, input int mode, input int ncyc,
                           input bit mixed, input logic [NCH-1:0] mask, input bit force_latch);
    int s;
    int e;
    int k;
    int pos;
    bit ev;
    bit eb;
    bit dense;
    s = cyc + 2;
    e = s - 1 + ncyc;
    for (int a = 0; a < 64; a++)
      for (int ch = 0; ch < NCH; ch++) exp_cnt[a][ch] = 0;
    for (int i = 0; i < ncyc + 10; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == s - 1) begin
        win_len   = WW'(w);
        edge_mode = 2'(mode);
        enable    = 1'b1;
      end else if (cyc == e) begin
        enable = 1'b0;
      end else if (w >= 8 && cyc > s && cyc < e) begin
        pos     = (cyc - s) % (w + 1);
        win_len = (pos >= 2 && pos + 3 <= w) ? WW'(w + 5) : WW'(w);
      end
      if (cyc >= s && cyc <= e) begin
        dense = !mixed || (((cyc - s) / (w + 1)) % 2 == 0);
        for (int ch = 0; ch < NCH; ch++) begin
          if (mask[ch]) begin
            if (hold[ch] > 0) begin
              hold[ch]--;
            end else begin
              toggle(ch, w, s, mode);
              if (!mixed)     hold[ch] = $urandom_range(HMIN + 12, HMIN + 2);
              else if (dense) hold[ch] = $urandom_range(HMIN + 1, HMIN);
              else            hold[ch] = $urandom_range(40, 15);
            end
          end
        end
        if (force_latch && (cyc == s + w - LAT || cyc == s + w - LAT + 12))
          toggle(3, w, s, mode);
      end
      @(negedge clk);
      ev = (w != 0) && (cyc - 1 >= s) && (cyc - 1 <= e) && (((cyc - 1 - s) % (w + 1)) == w);
      eb = (w != 0) && (cyc >= s) && (cyc <= e);
      if (ev) begin
        k = (cyc - 1 - s) / (w + 1);
        for (int ch = 0; ch < NCH; ch++) begin
          held_cnt[ch] = (exp_cnt[k][ch] > MAXC) ? MAXC : exp_cnt[k][ch];
          held_sat[ch] = (exp_cnt[k][ch] >= MAXC);
        end
      end
      chk("valid", 64'(valid), 64'(ev));
      chk("busy", 64'(busy), 64'(eb));
      chk_held();
    end
  endtask

  initial begin
    bit got;
    int s;
    int r;
    rst       = 1'b1;
    enable    = 1'b0;
    pulse_in  = '0;
    win_len   = '0;
    edge_mode = 2'b00;
    for (int ch = 0; ch < NCH; ch++) begin
      lvl[ch] = 1'b0; hold[ch] = 0; held_cnt[ch] = 0; held_sat[ch] = 1'b0;
    end
    #2;
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk_held();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle with enable low: inputs toggle, nothing happens.
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); cyc++; #1;
      pulse_in = NCH'($urandom);
      @(negedge clk);
      chk("idle_valid", 64'(valid), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk_held();
    end
    @(posedge clk); cyc++; #1;
    pulse_in = '0;
    repeat (8) begin @(posedge clk); cyc++; end
    #1;

    run_phase(100, 0, 420, 1'b0, 4'hF, 1'b0);   // rising, basic windows
    run_phase(40, 1, 170, 1'b0, 4'hF, 1'b0);    // falling
    run_phase(40, 2, 170, 1'b0, 4'hF, 1'b0);    // both edges
    run_phase(250, 3, 1100, 1'b1, 4'hF, 1'b0);  // code 11, saturating/clearing windows
    run_phase(30, 2, 70, 1'b0, 4'h7, 1'b1);     // edge landing in LATCH cycle
    run_phase(50, 0, 30, 1'b0, 4'hF, 1'b0);     // abort mid-window
    run_phase(0, 0, 30, 1'b0, 4'hF, 1'b0);      // win_len=0 never starts
    run_phase(7, 2, 60, 1'b0, 4'hF, 1'b0);      // short back-to-back windows

    // Asynchronous reset in the middle of a window.
    @(posedge clk); cyc++; #1;
    win_len = WW'(30);
    enable  = 1'b1;
    repeat (10) begin @(posedge clk); cyc++; end
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_valid", 64'(valid), 64'd0);
    for (int ch = 0; ch < NCH; ch++) begin held_cnt[ch] = 0; held_sat[ch] = 1'b0; end
    chk_held();
    @(posedge clk); cyc++; #1;
    rst      = 1'b0;
    enable   = 1'b0;
    pulse_in = '0;
    for (int ch = 0; ch < NCH; ch++) begin lvl[ch] = 1'b0; hold[ch] = 0; end
    repeat (12) begin @(posedge clk); cyc++; end
    #1;

    // Glitch step: a 2-cycle and a 6-cycle high pulse on ch0 in one window.
    win_len   = WW'(60);
    edge_mode = 2'b00;
    enable    = 1'b1;
    s         = cyc + 1;
    got       = 1'b0;
    for (int i = 0; i < 150 && !got; i++) begin
      @(posedge clk); cyc++; #1;
      r           = cyc - s;
      pulse_in[0] = ((r >= 5 && r < 7) || (r >= 25 && r < 31));
      @(negedge clk);
      if (valid === 1'b1) got = 1'b1;
    end
    enable = 1'b0;
    chk("glitch_valid_seen", 64'(got), 64'd1);
    chk("glitch_ch0", 64'(count_out[0 +: CW]), 64'(GLITCH_EXP));
    chk("glitch_ch1", 64'(count_out[CW +: CW]), 64'd0);
    chk("glitch_sat", 64'(sat_out), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
